// File: rtl/ram_port_arbiter.sv
// Arbitrates the byte-wide RAM port between instruction fetch and load/store.
// Each granted word-level request is split into 1/2/4 byte beats and finished with a one-cycle done pulse.
module ram_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    output logic [31:0] if_data_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_done_o,
    output logic [31:0] mem_rdata_o,
    output logic        ram_re_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [7:0]  ram_wdata_o,
    input  logic [7:0]  ram_rdata_i,
    output logic [2:0]  dbg_state_o
);
    // Handshake: a requester holds req with stable operands until its done pulse;
    // operands are sampled only in the grant cycle, and in the cycle after done
    // the requester either drops req or presents its next transaction.
    typedef enum logic [2:0] {S_IDLE, S_RD, S_DRAIN, S_WR, S_DONE} state_t;
    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    state_t      state_q, state_d;
    logic        last_grant_q, owner_q, we_q, uns_q, rd_v1_q, rd_v2_q;
    logic [31:0] addr_q, wdata_q, rbuf_q, if_data_q, mem_rdata_q;
    logic [2:0]  n_q, issue_q, cap_q;
    logic        grant_if, grant_mem, grant_any, last_issue, last_cap;
    logic [2:0]  n_grant;
    logic [31:0] rd_word, rd_ext;

    always_comb begin
        grant_if  = if_req_i && (!mem_req_i || last_grant_q == OWN_MEM);
        grant_mem = mem_req_i && !grant_if;
        grant_any = (state_q == S_IDLE) && (grant_if || grant_mem);
        if (grant_if || mem_size_i[1]) n_grant = 3'd4;
        else if (mem_size_i[0])        n_grant = 3'd2;
        else                           n_grant = 3'd1;
        last_issue = (issue_q == n_q - 3'd1);
        last_cap   = rd_v2_q && (cap_q == n_q - 3'd1);
    end

    // Assembled word including the byte arriving this cycle, so results are valid in DONE.
    always_comb begin
        rd_word = rbuf_q;
        rd_word[{cap_q[1:0], 3'b000} +: 8] = ram_rdata_i;
        if (n_q == 3'd1)      rd_ext = {{24{!uns_q && rd_word[7]}}, rd_word[7:0]};
        else if (n_q == 3'd2) rd_ext = {{16{!uns_q && rd_word[15]}}, rd_word[15:0]};
        else                  rd_ext = rd_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_any) state_d = (grant_mem && mem_we_i) ? S_WR : S_RD;
            S_RD:    if (last_issue) state_d = S_DRAIN;
            S_DRAIN: if (last_cap) state_d = S_DONE;
            S_WR:    if (last_issue) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_re_o    = (state_q == S_RD);
        ram_we_o    = (state_q == S_WR);
        ram_addr_o  = addr_q + {29'd0, issue_q};
        ram_wdata_o = wdata_q[{issue_q[1:0], 3'b000} +: 8];
        if_done_o   = (state_q == S_DONE) && (owner_q == OWN_IF);
        mem_done_o  = (state_q == S_DONE) && (owner_q == OWN_MEM);
        if_data_o   = if_data_q;
        mem_rdata_o = mem_rdata_q;
        dbg_state_o = state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= OWN_IF;
            owner_q      <= OWN_IF;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            rd_v1_q      <= 1'b0;
            rd_v2_q      <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rbuf_q       <= 32'd0;
            if_data_q    <= 32'd0;
            mem_rdata_q  <= 32'd0;
            n_q          <= 3'd0;
            issue_q      <= 3'd0;
            cap_q        <= 3'd0;
        end else begin
            // Read data returns two cycles after its issue cycle.
            rd_v1_q <= (state_q == S_RD);
            rd_v2_q <= rd_v1_q;
            if (grant_any) begin
                last_grant_q <= grant_mem;
                owner_q      <= grant_mem;
                addr_q       <= grant_mem ? mem_addr_i : if_addr_i;
                n_q          <= n_grant;
                we_q         <= grant_mem && mem_we_i;
                uns_q        <= mem_unsigned_i;
                wdata_q      <= mem_wdata_i;
                issue_q      <= 3'd0;
                cap_q        <= 3'd0;
                rbuf_q       <= 32'd0;
            end
            if (state_q == S_RD || state_q == S_WR) issue_q <= issue_q + 3'd1;
            if (rd_v2_q) begin
                rbuf_q <= rd_word;
                cap_q  <= cap_q + 3'd1;
            end
            if (state_q == S_DRAIN && last_cap && !we_q) begin
                if (owner_q == OWN_IF) if_data_q   <= rd_word;
                else                   mem_rdata_q <= rd_ext;
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a transaction-level model predicts RAM beats, done cycles and data;
// a negedge monitor pops and compares whenever the DUT drives the port or pulses done.
module tb_ram_port_arbiter;
  logic        clk, rst;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = 32'd0;
  logic        if_done_o;
  logic [31:0] if_data_o;
  logic        mem_req_i = 1'b0, mem_we_i = 1'b0, mem_unsigned_i = 1'b0;
  logic [1:0]  mem_size_i = 2'd0;
  logic [31:0] mem_addr_i = 32'd0, mem_wdata_i = 32'd0;
  logic        mem_done_o;
  logic [31:0] mem_rdata_o;
  logic        ram_re_o, ram_we_o;
  logic [31:0] ram_addr_o;
  logic [7:0]  ram_wdata_o;
  logic [7:0]  ram_rdata_i = 8'd0;
  logic [2:0]  dbg_state_o;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int unsigned cyc = 0;
  int          vectors = 0, miscompares = 0;
  logic [63:0] exp_if_q[$];
  logic [63:0] exp_mem_q[$];
  logic [40:0] exp_ram_q[$];
  logic [7:0]  ram_wr[logic [31:0]];
  logic [7:0]  ref_wr[logic [31:0]];
  logic [7:0]  rd_pipe = 8'd0;
  logic        rr_mem = 1'b0;
  logic [31:0] ref_mem_rdata = 32'd0;
  txn_t        if_list[$];
  txn_t        mem_list[$];

  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o), .if_data_o(if_data_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_unsigned_i(mem_unsigned_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
    .ram_re_o(ram_re_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial rst = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'h5C;
  endfunction
  function automatic logic [7:0] ram_read(input logic [31:0] a);
    return ram_wr.exists(a) ? ram_wr[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] ref_read(input logic [31:0] a);
    return ref_wr.exists(a) ? ref_wr[a] : init_byte(a);
  endfunction

  // RAM device: writes on the edge, read data two cycles after the issue cycle
  always @(posedge clk) begin
    if (ram_we_o) ram_wr[ram_addr_o] = ram_wdata_o;
    ram_rdata_i <= rd_pipe;
    rd_pipe     <= ram_re_o ? ram_read(ram_addr_o) : 8'h00;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected activity 0x%0h (cycle %0d)", name, act, cyc);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [63:0] e;
    logic [40:0] r;
    if (ram_re_o || ram_we_o) begin
      chk("ram_re_we_exclusive", 64'(ram_re_o & ram_we_o), 64'd0);
      if (exp_ram_q.size() == 0) flag("ram_unexpected", 64'({ram_we_o, ram_addr_o, ram_wdata_o}));
      else begin
        r = exp_ram_q.pop_front();
        chk("ram_access", 64'({ram_we_o, ram_addr_o, ram_we_o ? ram_wdata_o : 8'h00}), 64'(r));
      end
    end
    if (if_done_o) begin
      if (exp_if_q.size() == 0) flag("if_done_unexpected", 64'(if_data_o));
      else begin
        e = exp_if_q.pop_front();
        chk("if_done_cycle", 64'(cyc), 64'(e[63:32]));
        chk("if_data", 64'(if_data_o), 64'(e[31:0]));
      end
    end
    if (mem_done_o) begin
      if (exp_mem_q.size() == 0) flag("mem_done_unexpected", 64'(mem_rdata_o));
      else begin
        e = exp_mem_q.pop_front();
        chk("mem_done_cycle", 64'(cyc), 64'(e[63:32]));
        chk("mem_rdata", 64'(mem_rdata_o), 64'(e[31:0]));
      end
    end
  end

  // Reference: serve both request streams with round-robin ties, one transaction at a time.
  task automatic model_run(input int unsigned t0);
    int unsigned t, lat;
    int          ii, mi, n;
    logic        pick_mem;
    txn_t        x;
    logic [31:0] val, a;
    t = t0; ii = 0; mi = 0;
    while (ii < if_list.size() || mi < mem_list.size()) begin
      if (ii < if_list.size() && mi < mem_list.size()) pick_mem = !rr_mem;
      else pick_mem = (mi < mem_list.size());
      rr_mem = pick_mem;
      if (pick_mem) begin x = mem_list[mi]; mi++; end
      else begin x = if_list[ii]; x.we = 1'b0; ii++; end
      n = (!pick_mem || x.size[1]) ? 4 : (x.size[0] ? 2 : 1);
      val = 32'd0;
      for (int k = 0; k < n; k++) begin
        a = x.addr + 32'(k);
        if (x.we) begin
          exp_ram_q.push_back({1'b1, a, x.wdata[8*k +: 8]});
          ref_wr[a] = x.wdata[8*k +: 8];
        end else begin
          exp_ram_q.push_back({1'b0, a, 8'h00});
          val[8*k +: 8] = ref_read(a);
        end
      end
      if (pick_mem && !x.we && n < 4 && !x.uns && val[8*n-1]) val = val | (32'hFFFFFFFF << (8*n));
      lat = x.we ? 32'(n + 1) : 32'(n + 3);
      if (pick_mem) begin
        if (!x.we) ref_mem_rdata = val;
        exp_mem_q.push_back({t + lat, ref_mem_rdata});
      end else begin
        exp_if_q.push_back({t + lat, val});
      end
      t = t + lat + 1;
    end
  endtask

  task automatic wait_done(input logic is_mem);
    int   c;
    logic seen;
    c = 0; seen = 1'b0;
    while (!seen && c < 300) begin
      @(negedge clk);
      seen = is_mem ? mem_done_o : if_done_o;
      c++;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_done_timeout: no done after %0d cycles, required a done pulse", is_mem ? "mem" : "if", c);
    end
  endtask

  // driver tasks: each keeps req high back-to-back across its list
  task automatic drive_if_list();
    for (int i = 0; i < if_list.size(); i++) begin
      if_req_i  = 1'b1;
      if_addr_i = if_list[i].addr;
      wait_done(1'b0);
      @(posedge clk); #1;
    end
    if_req_i = 1'b0;
  endtask

  task automatic drive_mem_list();
    for (int i = 0; i < mem_list.size(); i++) begin
      mem_req_i      = 1'b1;
      mem_we_i       = mem_list[i].we;
      mem_size_i     = mem_list[i].size;
      mem_unsigned_i = mem_list[i].uns;
      mem_addr_i     = mem_list[i].addr;
      mem_wdata_i    = mem_list[i].wdata;
      wait_done(1'b1);
      @(posedge clk); #1;
    end
    mem_req_i = 1'b0;
  endtask

  task automatic run_batch();
    @(posedge clk); #1;
    model_run(cyc);
    fork
      drive_if_list();
      drive_mem_list();
    join
    if_list.delete();
    mem_list.delete();
  endtask

  function automatic txn_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata);
    txn_t x;
    x.we = we; x.size = size; x.uns = uns; x.addr = addr; x.wdata = wdata;
    return x;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram_wr[a] = b;
    ref_wr[a] = b;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ram_re"},    64'(ram_re_o), 64'd0);
    chk({tag, "_ram_we"},    64'(ram_we_o), 64'd0);
    chk({tag, "_ram_addr"},  64'(ram_addr_o), 64'd0);
    chk({tag, "_ram_wdata"}, 64'(ram_wdata_o), 64'd0);
    chk({tag, "_if_done"},   64'(if_done_o), 64'd0);
    chk({tag, "_mem_done"},  64'(mem_done_o), 64'd0);
    chk({tag, "_if_data"},   64'(if_data_o), 64'd0);
    chk({tag, "_mem_rdata"}, 64'(mem_rdata_o), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1 check_quiet("reset");
    rst = 1'b1;
    @(posedge clk); #1 check_quiet("post_reset");

    // tie right after reset: MEM first, then IF beats MEM's next request
    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    preload(32'h300, 8'h80);
    if_list.push_back(mk(1'b0, 2'b10, 1'b0, 32'h100, 32'd0));
    mem_list.push_back(mk(1'b0, 2'b00, 1'b0, 32'h300, 32'd0));
    mem_list.push_back(mk(1'b0, 2'b00, 1'b1, 32'h300, 32'd0));
    run_batch();

    if_list.push_back(mk(1'b0, 2'b10, 1'b0, 32'h100, 32'd0));
    run_batch();
    mem_list.push_back(mk(1'b1, 2'b01, 1'b0, 32'h200, 32'hDEADBEEF));
    run_batch();
    mem_list.push_back(mk(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'd0));
    run_batch();

    for (int b = 0; b < 25; b++) begin
      int nif, nmem;
      nif  = $urandom_range(0, 3);
      nmem = $urandom_range(0, 3);
      for (int i = 0; i < nif; i++) begin
        a = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
        if_list.push_back(mk(1'b0, 2'b10, 1'b0, a, 32'd0));
      end
      for (int i = 0; i < nmem; i++) begin
        a = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
        mem_list.push_back(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                              1'($urandom_range(0, 1)), a, $urandom));
      end
      run_batch();
    end

    // reset during cycle 3 of a word store: only beats 0 and 1 reach the RAM
    @(posedge clk); #1;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b10; mem_unsigned_i = 1'b0;
    mem_addr_i = 32'h400; mem_wdata_i = 32'hCAFEF00D;
    exp_ram_q.push_back({1'b1, 32'h400, 8'h0D}); ref_wr[32'h400] = 8'h0D;
    exp_ram_q.push_back({1'b1, 32'h401, 8'hF0}); ref_wr[32'h401] = 8'hF0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_quiet("mid_reset");
    chk("mid_reset_beats_drained", 64'(exp_ram_q.size()), 64'd0);
    mem_req_i = 1'b0;
    rr_mem = 1'b0;
    ref_mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    if_list.push_back(mk(1'b0, 2'b10, 1'b0, 32'h400, 32'd0));
    run_batch();
    repeat (4) @(posedge clk);

    chk("if_queue_empty",  64'(exp_if_q.size()), 64'd0);
    chk("mem_queue_empty", 64'(exp_mem_q.size()), 64'd0);
    chk("ram_queue_empty", 64'(exp_ram_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
